// File: rtl/title_pkg.sv
// -----------------------------------------------------------------------------
// title_pkg
// Shared types and constants for the title text path: glyph code width, the
// blank glyph, displayed slot count, shadow depth / scroll rate used when
// TITLE_SCROLL_EN is defined, and the loader FSM state encoding.
// -----------------------------------------------------------------------------
package title_pkg;

  localparam int CHAR_W        = 9;
  localparam int NUM_CHARS     = 12;
  localparam int MAX_LEN       = 24;
  localparam int SCROLL_FRAMES = 30;

  typedef logic [CHAR_W-1:0] font_code_t;

  localparam font_code_t BLANK_CODE = 9'h100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PEND = 2'd2
  } title_state_e;

endpackage

// File: rtl/title_char_buffer_if.sv
// -----------------------------------------------------------------------------
// title_char_buffer_if
// Load/commit handshake between a title source and title_char_buffer.
//   start      : one-cycle pulse, begin a new title load
//   char_valid : ASCII byte valid
//   char_ascii : ASCII byte, 8'h00 terminates the title
//   char_ready : buffer accepts a byte this cycle
//   frame_tick : one-cycle pulse at the start of vertical blank
//   busy       : high from start until the commit completes
// master = title source / bench, slave = buffer.
// -----------------------------------------------------------------------------
interface title_char_buffer_if;

  logic       start;
  logic       char_valid;
  logic [7:0] char_ascii;
  logic       char_ready;
  logic       frame_tick;
  logic       busy;

  modport master (
    output start, char_valid, char_ascii, frame_tick,
    input  char_ready, busy
  );

  modport slave (
    input  start, char_valid, char_ascii, frame_tick,
    output char_ready, busy
  );

endinterface

// File: rtl/ascii_to_font.sv
// -----------------------------------------------------------------------------
// ascii_to_font
// Pure combinational ASCII -> 9-bit font-ROM offset map, shared by text
// displays. Letters of either case map to (alphabet position, a=1) * 8;
// every other byte maps to the blank glyph.
//   ascii_i : ASCII byte
//   code_o  : font-ROM offset
// -----------------------------------------------------------------------------
module ascii_to_font
  import title_pkg::*;
(
  input  logic [7:0] ascii_i,
  output font_code_t code_o
);

  logic [7:0] pos_s;

  // Letter detection and offset computation
  always_comb begin
    pos_s  = 8'h00;
    code_o = BLANK_CODE;
    if (ascii_i >= 8'h61 && ascii_i <= 8'h7a) begin
      pos_s  = ascii_i - 8'h60;
      code_o = {1'b0, pos_s[4:0], 3'b000};
    end else if (ascii_i >= 8'h41 && ascii_i <= 8'h5a) begin
      pos_s  = ascii_i - 8'h40;
      code_o = {1'b0, pos_s[4:0], 3'b000};
    end else begin
      code_o = BLANK_CODE;
    end
  end

endmodule

// File: rtl/title_char_buffer.sv
// -----------------------------------------------------------------------------
// title_char_buffer
// Streams a title as ASCII bytes into a shadow buffer of font codes and
// commits it to the 12 displayed slots on the first frame_tick after the load
// ends, so the renderer never sees a half-written title.
//   clk, reset  : clock, asynchronous active-high reset
//   bus (slave) : start / char_valid / char_ascii / char_ready / frame_tick / busy
//   char1..12   : registered font offsets, slot 1 leftmost
// Optional feature macro TITLE_SCROLL_EN: MAX_LEN-deep buffers and a marquee
// for titles longer than 12 characters (offset advances every SCROLL_FRAMES
// ticks, wrapping over length+1 with an implicit trailing blank). Without it
// the load ends after 12 bytes and nothing scrolls.
// -----------------------------------------------------------------------------
module title_char_buffer
  import title_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  title_char_buffer_if.slave bus,
  output font_code_t         char1,
  output font_code_t         char2,
  output font_code_t         char3,
  output font_code_t         char4,
  output font_code_t         char5,
  output font_code_t         char6,
  output font_code_t         char7,
  output font_code_t         char8,
  output font_code_t         char9,
  output font_code_t         char10,
  output font_code_t         char11,
  output font_code_t         char12
);

`ifdef TITLE_SCROLL_EN
  localparam int SH_N = MAX_LEN;
`else
  localparam int SH_N = NUM_CHARS;
`endif
  localparam int IDX_W = $clog2(SH_N + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SH_N - 1);

  title_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  font_code_t       shadow_q [SH_N];
  font_code_t       char_q   [NUM_CHARS];

  logic             char_ready_s;
  logic             xfer_s;
  logic             clr_s;
  logic             wr_en_s;
  logic             commit_s;
  font_code_t       code_s;

  ascii_to_font u_map (
    .ascii_i (bus.char_ascii),
    .code_o  (code_s)
  );

  // char_ready depends on state only; start in the same cycle still blocks
  // the transfer inside the FSM.
  assign char_ready_s   = (state_q == ST_LOAD);
  assign xfer_s         = char_ready_s & bus.char_valid;
  assign bus.char_ready = char_ready_s;
  assign bus.busy       = busy_q;

  // Loader FSM next-state and control decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    clr_s    = 1'b0;
    wr_en_s  = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
          clr_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          clr_s   = 1'b1;
        end else if (xfer_s) begin
          if (bus.char_ascii == 8'h00) begin
            state_d = ST_PEND;
          end else begin
            wr_en_s = 1'b1;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              state_d = ST_PEND;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_PEND: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          clr_s   = 1'b1;
        end else if (bus.frame_tick) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          commit_s = 1'b1;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, write index and busy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Shadow buffer: cleared on every start, written one entry per stored byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SH_N; i++) shadow_q[i] <= BLANK_CODE;
    end else if (clr_s) begin
      for (int i = 0; i < SH_N; i++) shadow_q[i] <= BLANK_CODE;
    end else if (wr_en_s) begin
      shadow_q[idx_q] <= code_s;
    end else begin
      shadow_q <= shadow_q;
    end
  end

`ifdef TITLE_SCROLL_EN
  localparam int FC_W = $clog2(SCROLL_FRAMES);

  font_code_t       disp_q [SH_N];
  logic [IDX_W-1:0] dlen_q;
  logic [IDX_W-1:0] off_q;
  logic [FC_W-1:0]  fcnt_q;

  logic             scroll_s;
  logic             step_s;
  logic [IDX_W-1:0] off_next_s;
  logic [IDX_W-1:0] win_len_s;
  logic [IDX_W-1:0] win_off_s;
  logic [5:0]       pos_s;
  font_code_t       win_s [NUM_CHARS];

  assign scroll_s   = (dlen_q > IDX_W'(NUM_CHARS));
  assign step_s     = ~commit_s & bus.frame_tick & scroll_s &
                      (fcnt_q == FC_W'(SCROLL_FRAMES - 1));
  assign off_next_s = (off_q == dlen_q) ? '0 : off_q + IDX_W'(1);

  // Window contents after this edge: a fresh commit starts at offset 0,
  // otherwise the (possibly stepped) offset over the displayed buffer.
  // Position equal to the length is the implicit trailing blank.
  always_comb begin
    pos_s = 6'd0;
    if (commit_s) begin
      win_len_s = idx_q;
      win_off_s = '0;
    end else begin
      win_len_s = dlen_q;
      win_off_s = step_s ? off_next_s : off_q;
    end
    for (int k = 0; k < NUM_CHARS; k++) begin
      pos_s = 6'(win_off_s) + 6'(k);
      if (win_len_s > IDX_W'(NUM_CHARS) && pos_s > 6'(win_len_s)) begin
        pos_s = pos_s - 6'(win_len_s) - 6'd1;
      end else begin
        pos_s = pos_s;
      end
      if (pos_s == 6'(win_len_s) || pos_s >= 6'(SH_N)) begin
        win_s[k] = BLANK_CODE;
      end else if (commit_s) begin
        win_s[k] = shadow_q[pos_s[IDX_W-1:0]];
      end else begin
        win_s[k] = disp_q[pos_s[IDX_W-1:0]];
      end
    end
  end

  // Displayed buffer, length, marquee offset and frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SH_N; i++) disp_q[i] <= BLANK_CODE;
      dlen_q <= '0;
      off_q  <= '0;
      fcnt_q <= '0;
    end else if (commit_s) begin
      disp_q <= shadow_q;
      dlen_q <= idx_q;
      off_q  <= '0;
      fcnt_q <= '0;
    end else if (bus.frame_tick && scroll_s) begin
      if (step_s) begin
        fcnt_q <= '0;
        off_q  <= off_next_s;
      end else begin
        fcnt_q <= fcnt_q + FC_W'(1);
      end
    end else begin
      fcnt_q <= fcnt_q;
    end
  end

  // Registered slot outputs, refreshed on commit or scroll step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++) char_q[i] <= BLANK_CODE;
    end else if (commit_s || step_s) begin
      char_q <= win_s;
    end else begin
      char_q <= char_q;
    end
  end
`else
  // Registered slot outputs, loaded from the shadow on commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++) char_q[i] <= BLANK_CODE;
    end else if (commit_s) begin
      char_q <= shadow_q;
    end else begin
      char_q <= char_q;
    end
  end
`endif

  assign char1  = char_q[0];
  assign char2  = char_q[1];
  assign char3  = char_q[2];
  assign char4  = char_q[3];
  assign char5  = char_q[4];
  assign char6  = char_q[5];
  assign char7  = char_q[6];
  assign char8  = char_q[7];
  assign char9  = char_q[8];
  assign char10 = char_q[9];
  assign char11 = char_q[10];
  assign char12 = char_q[11];

endmodule

// File: tb/tb_title_char_buffer.sv
// -----------------------------------------------------------------------------
// tb_title_char_buffer
// Directed self-checking bench for title_char_buffer: reset state, full and
// short titles, gapped valid, tick coinciding with the last byte, restart and
// abort, zero-length title, and the marquee when TITLE_SCROLL_EN is defined.
// -----------------------------------------------------------------------------
module tb_title_char_buffer;
  import title_pkg::*;

  typedef font_code_t title_t [12];

  logic clk;
  logic reset;
  font_code_t ch [12];
  int n_checks;
  int n_fail;

  title_char_buffer_if bus ();

  title_char_buffer dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .char1  (ch[0]),
    .char2  (ch[1]),
    .char3  (ch[2]),
    .char4  (ch[3]),
    .char5  (ch[4]),
    .char6  (ch[5]),
    .char7  (ch[6]),
    .char8  (ch[7]),
    .char9  (ch[8]),
    .char10 (ch[9]),
    .char11 (ch[10]),
    .char12 (ch[11])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_title(input string tag, input title_t exp);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s.char%0d", tag, i + 1), 32'(ch[i]), 32'(exp[i]));
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cnt;
    cnt = 0;
    bus.char_valid = 1'b1;
    bus.char_ascii = b;
    while (bus.char_ready !== 1'b1 && cnt < 50) begin
      step();
      cnt++;
    end
    if (cnt >= 50) check("ready_timeout", 32'd0, 32'd1);
    step();
    bus.char_valid = 1'b0;
    bus.char_ascii = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  title_t blank_t, pink_t, ab_t, al_t, hi_t;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    blank_t = '{9'h100, 9'h100, 9'h100, 9'h100, 9'h100, 9'h100,
                9'h100, 9'h100, 9'h100, 9'h100, 9'h100, 9'h100};
    pink_t  = '{9'h080, 9'h048, 9'h070, 9'h058, 9'h100, 9'h080,
                9'h008, 9'h070, 9'h0a0, 9'h040, 9'h028, 9'h090};
    ab_t    = '{9'h008, 9'h010, 9'h100, 9'h100, 9'h100, 9'h100,
                9'h100, 9'h100, 9'h100, 9'h100, 9'h100, 9'h100};
    al_t    = '{9'h008, 9'h010, 9'h018, 9'h020, 9'h028, 9'h030,
                9'h038, 9'h040, 9'h048, 9'h050, 9'h058, 9'h060};
    hi_t    = '{9'h040, 9'h048, 9'h100, 9'h100, 9'h100, 9'h100,
                9'h100, 9'h100, 9'h100, 9'h100, 9'h100, 9'h100};

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_ascii = 8'h00;
    bus.frame_tick = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // reset state
    check("rst.char_ready", 32'(bus.char_ready), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    expect_title("rst", blank_t);

    // full 12-character title
    pulse_start();
    check("pink.busy_start", 32'(bus.busy), 32'd1);
    check("pink.ready", 32'(bus.char_ready), 32'd1);
    send_str("pink panther");
`ifdef TITLE_SCROLL_EN
    send_byte(8'h00);
`else
    check("pink.ready_after12", 32'(bus.char_ready), 32'd0);
    bus.char_valid = 1'b1;
    bus.char_ascii = 8'h00;
    step();
    bus.char_valid = 1'b0;
`endif
    check("pink.busy_pend", 32'(bus.busy), 32'd1);
    expect_title("pink.pre", blank_t);
    tick();
    check("pink.busy_done", 32'(bus.busy), 32'd0);
    expect_title("pink.post", pink_t);

    // gapped valid: "AB" + terminator
    pulse_start();
    bus.char_valid = 1'b1; bus.char_ascii = 8'h41; step();
    bus.char_valid = 1'b0; bus.char_ascii = 8'h5a; step();
    bus.char_valid = 1'b1; bus.char_ascii = 8'h42; step();
    bus.char_valid = 1'b0; bus.char_ascii = 8'h5a; step();
    bus.char_valid = 1'b1; bus.char_ascii = 8'h00; step();
    bus.char_valid = 1'b0; step();
    check("ab.ready_pend", 32'(bus.char_ready), 32'd0);
    check("ab.pre_char1", 32'(ch[0]), 32'h080);
    tick();
    expect_title("ab", ab_t);

    // frame_tick together with the 12th byte must not commit
    pulse_start();
    send_str("abcdefghijk");
    bus.char_valid = 1'b1;
    bus.char_ascii = 8'h6c;
    bus.frame_tick = 1'b1;
    step();
    bus.char_valid = 1'b0;
    bus.frame_tick = 1'b0;
    step();
`ifdef TITLE_SCROLL_EN
    send_byte(8'h00);
`endif
    check("al.busy_pend", 32'(bus.busy), 32'd1);
    check("al.nocommit_char1", 32'(ch[0]), 32'h008);
    check("al.nocommit_char3", 32'(ch[2]), 32'h100);
    tick();
    check("al.busy_done", 32'(bus.busy), 32'd0);
    expect_title("al", al_t);

    // restart mid-load
    pulse_start();
    send_str("abcde");
    pulse_start();
    check("rs.keep_char12", 32'(ch[11]), 32'h060);
    send_str("hi");
    send_byte(8'h00);
    tick();
    expect_title("rs", hi_t);

    // abort a pending commit, then commit a zero-length title
    pulse_start();
    send_str("xy");
    send_byte(8'h00);
    pulse_start();
    tick();
    check("ab0.no_commit", 32'(ch[0]), 32'h040);
    check("ab0.busy", 32'(bus.busy), 32'd1);
    send_byte(8'h00);
    tick();
    check("zl.busy", 32'(bus.busy), 32'd0);
    expect_title("zl", blank_t);

`ifdef TITLE_SCROLL_EN
    // marquee over 14 letters a..n
    pulse_start();
    send_str("abcdefghijklmn");
    send_byte(8'h00);
    tick();
    check("sc.o0_char1", 32'(ch[0]), 32'h008);
    check("sc.o0_char12", 32'(ch[11]), 32'h060);
    for (int i = 0; i < 29; i++) tick();
    check("sc.hold_char1", 32'(ch[0]), 32'h008);
    tick();
    check("sc.o1_char1", 32'(ch[0]), 32'h010);
    check("sc.o1_char12", 32'(ch[11]), 32'h068);
    for (int i = 0; i < 13 * 30; i++) tick();
    check("sc.o14_char1", 32'(ch[0]), 32'h100);
    check("sc.o14_char2", 32'(ch[1]), 32'h008);
    for (int i = 0; i < 30; i++) tick();
    check("sc.wrap_char1", 32'(ch[0]), 32'h008);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
